// File: rtl/stack_arb_if.sv
// Requester and stack-side signal bundle for stack_arb.
// slave: arbiter view; master: requesters plus the attached stack.
interface stack_arb_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             ack0;
    logic             ack1;
    logic             err0;
    logic             err1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_full;
    logic             stk_empty;
    logic [LW-1:0]    level;

    modport slave (
        input  req0, req1, op0, op1, wdata0, wdata1, stk_dout, stk_full, stk_empty,
        output ack0, ack1, err0, err1, rdata0, rdata1, stk_push, stk_pop, stk_din, level
    );

    modport master (
        output req0, req1, op0, op1, wdata0, wdata1, stk_dout, stk_full, stk_empty,
        input  ack0, ack1, err0, err1, rdata0, rdata1, stk_push, stk_pop, stk_din, level
    );
endinterface

// File: rtl/stack_arb.sv
// Two-requester push/pop arbiter in front of a single stack.
// Define STACK_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module stack_arb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        rst,
    stack_arb_if.slave bus
);
    localparam int            LW     = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LvlMax = LW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           r_state;
    logic             r_gnt;
    logic [1:0]       r_ack;
    logic [1:0]       r_err;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;
    logic [LW-1:0]    r_level;

    logic             w_any;
    logic             w_gnt;
    logic             w_op;
    logic             w_refuse;
    logic [WIDTH-1:0] w_wdata;

    assign w_any = bus.req0 | bus.req1;

`ifdef STACK_ARB_RR_EN
    // r_rr_ptr names the requester favoured on the next simultaneous request.
    logic r_rr_ptr;
    assign w_gnt = (bus.req0 && bus.req1) ? r_rr_ptr : (bus.req1 & ~bus.req0);
`else
    assign w_gnt = ~bus.req0;
`endif

    assign w_op     = w_gnt ? bus.op1 : bus.op0;
    assign w_wdata  = w_gnt ? bus.wdata1 : bus.wdata0;
    assign w_refuse = w_op ? bus.stk_empty : bus.stk_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_gnt    <= 1'b0;
            r_ack    <= 2'b00;
            r_err    <= 2'b00;
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_din    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_level  <= '0;
`ifdef STACK_ARB_RR_EN
            r_rr_ptr <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_gnt <= w_gnt;
`ifdef STACK_ARB_RR_EN
                        r_rr_ptr <= ~w_gnt;
`endif
                        if (w_refuse) begin
                            r_ack[w_gnt] <= 1'b1;
                            r_err[w_gnt] <= 1'b1;
                            r_state      <= StResp;
                        end else begin
                            r_push  <= ~w_op;
                            r_pop   <= w_op;
                            r_din   <= w_wdata;
                            r_state <= StIssue;
                            if (w_op) begin
                                // Top word is captured before the stack moves on the ISSUE edge.
                                if (w_gnt) r_rdata1 <= bus.stk_dout;
                                else       r_rdata0 <= bus.stk_dout;
                                if (r_level != '0) r_level <= r_level - LW'(1);
                            end else if (r_level != LvlMax) begin
                                r_level <= r_level + LW'(1);
                            end
                        end
                    end
                end
                StIssue: begin
                    r_push       <= 1'b0;
                    r_pop        <= 1'b0;
                    r_ack[r_gnt] <= 1'b1;
                    r_state      <= StResp;
                end
                StResp: begin
                    r_ack   <= 2'b00;
                    r_err   <= 2'b00;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ack0     = r_ack[0];
    assign bus.ack1     = r_ack[1];
    assign bus.err0     = r_err[0];
    assign bus.err1     = r_err[1];
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign bus.stk_push = r_push;
    assign bus.stk_pop  = r_pop;
    assign bus.stk_din  = r_din;
    assign bus.level    = r_level;
endmodule

// File: tb/tb_stack_arb.sv
// Directed bench for stack_arb with a behavioural stack and a response scoreboard.
module tb_stack_arb;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic        who;
        logic        err;
        logic        pop;
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    stack_arb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Attached stack, sharing rst with the arbiter.
    logic [15:0] mem [DEPTH];
    logic [3:0]  sp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= 4'd0;
        end else if (bus.stk_push && sp < 4'd8) begin
            mem[sp[2:0]] <= bus.stk_din;
            sp           <= sp + 4'd1;
        end else if (bus.stk_pop && sp > 4'd0) begin
            sp <= sp - 4'd1;
        end
    end

    always_comb begin
        bus.stk_dout  = '0;
        if (sp > 4'd0) bus.stk_dout = mem[3'(sp - 4'd1)];
        bus.stk_full  = (sp == 4'd8);
        bus.stk_empty = (sp == 4'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic who, input logic op, input logic [15:0] wd,
                          input logic exp_err, input logic [15:0] exp_rd);
        exp_t e;
        int   cyc;
        int   n_push;
        int   n_pop;
        bit   got;
        e.who   = who;
        e.err   = exp_err;
        e.pop   = op;
        e.rdata = exp_rd;
        e.lat   = exp_err ? 1 : 2;
        sb.push_back(e);
        @(negedge clk);
        if (!who) begin
            bus.req0 = 1'b1; bus.op0 = op; bus.wdata0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.op1 = op; bus.wdata1 = wd;
        end
        @(posedge clk);
        cyc = 0; n_push = 0; n_pop = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            check("strobe_excl", 32'(bus.stk_push & bus.stk_pop), 32'd0);
            if (bus.stk_push) begin
                n_push++;
                check("stk_din", 32'(bus.stk_din), 32'(wd));
            end
            if (bus.stk_pop) n_pop++;
            if (bus.ack0 || bus.ack1) got = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        e = sb.pop_front();
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("ack0", 32'(bus.ack0), 32'(!e.who));
            check("ack1", 32'(bus.ack1), 32'(e.who));
            check("err_n", 32'(e.who ? bus.err1 : bus.err0), 32'(e.err));
            check("err_other", 32'(e.who ? bus.err0 : bus.err1), 32'd0);
            check("latency", 32'(cyc), 32'(e.lat));
            check("push_cnt", 32'(n_push), 32'(!e.err && !e.pop));
            check("pop_cnt", 32'(n_pop), 32'(!e.err && e.pop));
            if (e.pop && !e.err) check("rdata", 32'(e.who ? bus.rdata1 : bus.rdata0), 32'(e.rdata));
        end
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        int   cyc;
        bit   got;
        n_tests = 0;
        n_fail  = 0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = 1'b0; bus.op1 = 1'b0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_push", 32'(bus.stk_push), 32'd0);
        check("rst_pop", 32'(bus.stk_pop), 32'd0);
        check("rst_ack", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
        check("rst_din", 32'(bus.stk_din), 32'd0);
        check("rst_rdata", 32'({bus.rdata0, bus.rdata1}), 32'd0);
        rst = 1'b0;
        @(posedge clk);

        // Single push then pop through the other requester.
        run_op(1'b0, 1'b0, 16'hA5A5, 1'b0, 16'h0);
        check("level_after_push", 32'(bus.level), 32'd1);
        run_op(1'b1, 1'b1, 16'h0, 1'b0, 16'hA5A5);
        check("level_after_pop", 32'(bus.level), 32'd0);
        check("empty_after_pop", 32'(bus.stk_empty), 32'd1);

        // Pop on empty is refused.
        run_op(1'b0, 1'b1, 16'h0, 1'b1, 16'h0);
        check("level_empty_pop", 32'(bus.level), 32'd0);

        // Fill, overflow, drain in LIFO order.
        for (int i = 1; i <= 8; i++) run_op(1'b0, 1'b0, 16'(i), 1'b0, 16'h0);
        check("level_full", 32'(bus.level), 32'd8);
        run_op(1'b0, 1'b0, 16'd9, 1'b1, 16'h0);
        check("level_after_refuse", 32'(bus.level), 32'd8);
        for (int i = 8; i >= 1; i--) run_op(1'b1, 1'b1, 16'h0, 1'b0, 16'(i));
        check("level_drained", 32'(bus.level), 32'd0);
        check("rdata0_held", 32'(bus.rdata0), 32'd0);
        check("rdata1_held", 32'(bus.rdata1), 32'd1);

        // Both requesters held for four pushes.
        @(negedge clk);
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.wdata0 = 16'h0100;
        bus.req1 = 1'b1; bus.op1 = 1'b0; bus.wdata1 = 16'h0200;
        for (int i = 0; i < 4; i++) begin
`ifdef STACK_ARB_RR_EN
            e.who = 1'(i % 2);
`else
            e.who = 1'b0;
`endif
            e.err = 1'b0; e.pop = 1'b0; e.rdata = '0; e.lat = 2;
            sb.push_back(e);
            cyc = 0; got = 1'b0;
            while (!got && cyc < 8) begin
                @(negedge clk);
                cyc++;
                if (bus.ack0 || bus.ack1) got = 1'b1;
            end
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            e = sb.pop_front();
            check("arb_ack_seen", 32'(got), 32'd1);
            check("arb_who", 32'({bus.ack1, bus.ack0}), e.who ? 32'd2 : 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        check("level_arb", 32'(bus.level), 32'd4);
`ifdef STACK_ARB_RR_EN
        check("arb_top", 32'(bus.stk_dout), 32'h0200);
`else
        check("arb_top", 32'(bus.stk_dout), 32'h0100);
`endif

        // Reset landing in the ISSUE cycle aborts the push.
        bus.req0 = 1'b1; bus.op0 = 1'b0; bus.wdata0 = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        check("issue_push", 32'(bus.stk_push), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_push", 32'(bus.stk_push), 32'd0);
        check("abort_level", 32'(bus.level), 32'd0);
        check("abort_rdata1", 32'(bus.rdata1), 32'd0);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        end
        run_op(1'b0, 1'b0, 16'h1234, 1'b0, 16'h0);
        check("level_post_rst", 32'(bus.level), 32'd1);
        check("top_post_rst", 32'(bus.stk_dout), 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width, equal to the attached stack's WIDTH.
REQ-002 SHALL have parameter DEPTH, default 8: attached stack capacity in words.
REQ-003 SHALL have port clk  input  1  system clock; all controller state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1 each  requester n holds high until ack_n.
REQ-006 SHALL have ports op0/op1  input  1 each  0 = push, 1 = pop; held stable with req_n.
REQ-007 SHALL have ports wdata0/wdata1  input  WIDTH each  push data; held stable with req_n.
REQ-008 SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports err0/err1  output  1 each  high together with ack_n when the op was refused.
REQ-010 SHALL have ports rdata0/rdata1  output  WIDTH each  popped word; valid while ack_n is high and op was a successful pop.
REQ-011 SHALL have ports stk_push/stk_pop  output  1 each  registered strobes to the stack.
REQ-012 SHALL have port stk_din  output  WIDTH  registered push data to the stack.
REQ-013 SHALL have ports stk_dout  input  WIDTH, stk_full/stk_empty  input  1 each  stack top-of-stack word and flags.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current stack occupancy, 0..DEPTH.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE (normal path) and IDLE -> RESP -> IDLE (error path).
REQ-016 SHALL, in IDLE with any req high, grant exactly one requester at that rising edge, per REQ-027.
REQ-017 SHALL refuse the grant when the op is a push and stk_full=1, or a pop and stk_empty=1: no strobe, go to RESP with err_n=1.
REQ-018 SHALL, for an accepted op, drive stk_push or stk_pop high for exactly one cycle (the ISSUE cycle), with stk_din=wdata_n.
REQ-019 SHALL, for an accepted pop, capture stk_dout into rdata_n at the grant edge, before the stack moves.
REQ-020 SHALL assert ack_n (and err_n if refused) for exactly the RESP cycle; the other requester's ack/err SHALL stay 0.
REQ-021 SHALL give latency, grant edge to ack high: 2 cycles when accepted, 1 cycle when refused; at most one op per 3 cycles.
REQ-022 SHALL sample req/op/flags only in IDLE; a req still high in the IDLE after its ack SHALL be treated as a new request.
REQ-023 SHALL increment level on each accepted push and decrement it on each accepted pop, saturating at DEPTH and 0.
REQ-024 SHALL never assert stk_push and stk_pop together, and never strobe outside ISSUE.
REQ-025 SHALL hold rdata_n unchanged except on a capture for requester n.

Reset
REQ-026 SHALL, while rst is high and regardless of clk: state=IDLE; stk_push, stk_pop, ack0/1, err0/1 = 0; stk_din, rdata0/1 = 0; level=0; RR pointer=0 (requester 0 favoured). A reset during ISSUE SHALL abort the op with no ack; the stack SHALL share this rst.

Configuration
REQ-027 SHALL define macro STACK_ARB_RR_EN; if it is defined, simultaneous requests SHALL be served round-robin: the requester not granted most recently wins, and the pointer SHALL update on every grant, including refusals. If it is undefined, requester 0 SHALL always win and no pointer SHALL exist.

Verification
REQ-028 Reset, then req0 push 16'hA5A5 -> stk_push high 1 cycle with stk_din=A5A5; ack0=1, err0=0 two cycles after the grant; level=1.
REQ-029 Then req1 pop -> rdata1=16'hA5A5 with ack1=1, err1=0; level=0; stk_empty=1 afterwards.
REQ-030 Pop on an empty stack -> no strobe; ack=1 and err=1 one cycle after the grant; level stays 0.
REQ-031 8 pushes 1..8, then a 9th push -> 9th refused with err=1; level=8; 8 pops return 8..1 in order.
REQ-032 req0 and req1 held together for 4 ops with RR_EN -> grants 0,1,0,1; without the macro -> grants 0,0,0,0 while req0 is held.
REQ-033 rst pulsed during the ISSUE cycle -> strobes drop immediately, no ack is issued, level=0, and the next request completes normally.
